rambus_openram_arb: RTL and testbench
=====================================

RAMBUS_OPENRAM_ARB -- requirements
Module: rambus_openram_arb

Interface
REQ-001 SHALL have parameter: RAM_AW, 8, RAM word-address width (256 x 32-bit words).
REQ-002 SHALL have port: wb_clk_i  in  1  single clock for all logic; also the RAM clock.
REQ-003 SHALL have port: wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports, per master port m0 and m1: mN_stb_i  in  1; mN_cyc_i  in  1; mN_we_i  in  1; mN_sel_i  in  4 (byte enables); mN_dat_i  in  32 (write data); mN_adr_i  in  10 (word address).
REQ-005 SHALL have ports, per master port: mN_ack_o  out  1 (transfer done); mN_dat_o  out  32 (read data).
REQ-006 SHALL have ports: ram_clk0  out  1 (equals wb_clk_i); ram_csb0  out  1 (chip select, active-low); ram_web0  out  1 (write enable, active-low).
REQ-007 SHALL have ports: ram_wmask0  out  4; ram_addr0  out  RAM_AW; ram_din0  out  32; ram_dout0  in  32 (read data).
REQ-008 SHALL have port: grant_o  out  2 (one-hot owner of the current transfer; 00 when idle).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RDWAIT and ACK.
REQ-010 A request on port N SHALL be mN_cyc_i & mN_stb_i, sampled only in IDLE.
REQ-011 Arbitration SHALL be round-robin: if both ports request, grant the port not granted last; if one requests, grant it.
REQ-012 The last-grant pointer SHALL reset so that m0 wins the first contention.
REQ-013 On a grant (IDLE edge), the block SHALL register csb0=0, web0=~we, wmask0=sel, addr0=adr[RAM_AW-1:0], din0=dat_i and grant_o, then enter ACCESS.
REQ-014 RAM outputs SHALL be registered and SHALL hold stable for the whole ACCESS cycle.
REQ-015 ACCESS SHALL last one cycle; on exit the block SHALL set csb0=1 and web0=1.
REQ-016 On a write, ACCESS SHALL go to ACK.
REQ-017 On a read, ACCESS SHALL go to RDWAIT; RDWAIT SHALL capture ram_dout0 into mN_dat_o and go to ACK.
REQ-018 Latency, with cycle 0 = the request sampled in IDLE: write ack SHALL be high in cycle 2; read ack SHALL be high in cycle 3.
REQ-019 ACK SHALL assert mN_ack_o of the granted port for exactly one cycle, then return to IDLE.
REQ-020 The earliest next grant SHALL be in the cycle after ACK, giving a minimum of 3 cycles per write and 4 per read.
REQ-021 The non-granted port SHALL see ack=0 and SHALL keep waiting; its request SHALL be held by its master.
REQ-022 If adr[9:RAM_AW] != 0, the block SHALL NOT assert csb0 and SHALL NOT write.
REQ-023 For an out-of-range address the block SHALL still follow the same state sequence and latency; on a read it SHALL return 32'h0.
REQ-024 sel=4'b0000 on a write SHALL issue the RAM cycle with wmask0=0, so no bytes change, and SHALL ack normally.
REQ-025 If the granted master drops cyc before its ack, the block SHALL still complete the RAM access; a write already in ACCESS SHALL be committed.
REQ-026 In that abort case the ack SHALL be suppressed and the block SHALL return to IDLE on schedule.
REQ-027 mN_dat_o SHALL hold its last captured value until the next read completes on that port.
REQ-028 Read data SHALL be captured only on the port that owns the read.
REQ-029 ram_clk0 SHALL be a direct assignment from wb_clk_i.

Reset
REQ-030 While wb_rst_ni=0 (asynchronous), the block SHALL force state=IDLE, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, grant_o=00, both acks=0, both dat_o=0 and pointer=m1-last.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no ack, and reset SHALL take effect without a clock edge.
REQ-032 Release of wb_rst_ni SHALL be synchronised externally; the first grant SHALL be possible on the first edge after release.

Verification
REQ-033 The bench SHALL cover: m0 writes 0xDEADBEEF to adr 0x005 with sel=F, then reads adr 0x005 -> write ack in cycle 2, read ack in cycle 3, m0_dat_o=0xDEADBEEF.
REQ-034 The bench SHALL cover: both ports request writes in the same cycle just after reset -> m0 is granted first (grant_o=01), m1 second (10), and on a third simultaneous request m0 is granted again.
REQ-035 The bench SHALL cover: write 0x11223344, then a write of 0xAABBCCDD with sel=0101, then a read -> returns 0x11BB33DD.
REQ-036 The bench SHALL cover: a read at adr 0x300 -> csb0 never low, ack in cycle 3, dat_o=0.
REQ-037 The bench SHALL cover: a write whose master drops cyc in ACCESS -> no ack, and a later read shows the new data.
REQ-038 The bench SHALL cover: wb_rst_ni pulsed low during RDWAIT -> all outputs reach reset values immediately, no ack, and the next request is serviced normally.

Source files
------------

// File: rtl/rambus_openram_arb_if.sv
// rambus_openram_arb_if: one Wishbone-style master port of the OpenRAM arbiter
interface rambus_openram_arb_if;
  logic        stb_i;
  logic        cyc_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [9:0]  adr_i;
  logic        ack_o;
  logic [31:0] dat_o;
  modport slave (input stb_i, cyc_i, we_i, sel_i, dat_i, adr_i, output ack_o, dat_o);
  modport master (output stb_i, cyc_i, we_i, sel_i, dat_i, adr_i, input ack_o, dat_o);
endinterface

// File: rtl/rambus_openram_arb.sv
// rambus_openram_arb: round-robin arbiter sharing one OpenRAM port between two masters
module rambus_openram_arb #(
  parameter int RAM_AW = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  rambus_openram_arb_if.slave m0,
  rambus_openram_arb_if.slave m1,
  output logic                ram_clk0,
  output logic                ram_csb0,
  output logic                ram_web0,
  output logic [3:0]          ram_wmask0,
  output logic [RAM_AW-1:0]   ram_addr0,
  output logic [31:0]         ram_din0,
  input  logic [31:0]         ram_dout0,
  output logic [1:0]          grant_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;
  state_t state, state_nx;
  logic req0, req1, pick1, last, oor, we_q, abort, own_cyc, done_ok, we_sel;
  logic [9:0] adr;
  assign ram_clk0 = wb_clk_i;
  assign req0 = m0.cyc_i & m0.stb_i;
  assign req1 = m1.cyc_i & m1.stb_i;
  // m1 wins a contention only when m0 owned the previous transfer
  assign pick1 = req1 & (~req0 | ~last);
  assign adr = pick1 ? m1.adr_i : m0.adr_i;
  assign we_sel = pick1 ? m1.we_i : m0.we_i;
  assign own_cyc = grant_o[1] ? m1.cyc_i : m0.cyc_i;
  assign done_ok = own_cyc & ~abort;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE   ? ((req0 | req1) ? ACCESS : IDLE) :
               state == ACCESS ? (we_q ? ACK : RDWAIT) :
               state == RDWAIT ? ACK : IDLE;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0  <= '0;
      ram_din0   <= '0;
      grant_o    <= '0;
      last       <= 1'b1;
      oor        <= 1'b0;
      we_q       <= 1'b0;
      abort      <= 1'b0;
      m0.ack_o   <= 1'b0;
      m1.ack_o   <= 1'b0;
      m0.dat_o   <= '0;
      m1.dat_o   <= '0;
    end else begin
      m0.ack_o <= 1'b0;
      m1.ack_o <= 1'b0;
      if (state == IDLE && (req0 | req1)) begin
        ram_csb0   <= |adr[9:RAM_AW];
        ram_web0   <= ~we_sel;
        ram_wmask0 <= pick1 ? m1.sel_i : m0.sel_i;
        ram_addr0  <= adr[RAM_AW-1:0];
        ram_din0   <= pick1 ? m1.dat_i : m0.dat_i;
        grant_o    <= {pick1, ~pick1};
        last       <= pick1;
        oor        <= |adr[9:RAM_AW];
        we_q       <= we_sel;
        abort      <= 1'b0;
      end
      // a master that lets go of cyc mid-transfer loses its ack, but the RAM cycle still finishes
      if (state == ACCESS || state == RDWAIT) abort <= abort | ~own_cyc;
      if (state == ACCESS) begin
        ram_csb0 <= 1'b1;
        ram_web0 <= 1'b1;
      end
      if (state_nx == ACK && done_ok) begin
        m0.ack_o <= ~grant_o[1];
        m1.ack_o <= grant_o[1];
      end
      if (state == RDWAIT && done_ok) begin
        if (grant_o[1]) m1.dat_o <= oor ? '0 : ram_dout0;
        else m0.dat_o <= oor ? '0 : ram_dout0;
      end
      if (state == ACK) grant_o <= '0;
    end
  end
endmodule

// File: tb/tb_rambus_openram_arb.sv
// tb_rambus_openram_arb: directed and randomized two-master checks against a transaction-level model
module tb_rambus_openram_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ram_clk0, ram_csb0, ram_web0;
  logic [3:0] ram_wmask0;
  logic [7:0] ram_addr0;
  logic [31:0] ram_din0, ram_dout0;
  logic [1:0] grant_o;
  int n_chk = 0, n_fail = 0, acks0 = 0, acks1 = 0, csb_lows = 0;

  rambus_openram_arb_if m0();
  rambus_openram_arb_if m1();

  rambus_openram_arb #(.RAM_AW(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .m0(m0), .m1(m1),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(ram_dout0), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // OpenRAM-like single port: registered read data, byte-masked writes
  logic [31:0] ram_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = '0;
    ram_dout0 <= '0;
    forever begin
      @(posedge ram_clk0);
      if (!ram_csb0) begin
        if (!ram_web0) begin
          for (int b = 0; b < 4; b++) if (ram_wmask0[b]) ram_mem[ram_addr0][8*b +: 8] = ram_din0[8*b +: 8];
        end else ram_dout0 <= ram_mem[ram_addr0];
      end
    end
  end

  function automatic logic cyc_of(input int p);
    return p != 0 ? m1.cyc_i : m0.cyc_i;
  endfunction

  function automatic logic ack_of(input int p);
    return p != 0 ? m1.ack_o : m0.ack_o;
  endfunction

  // Reference model: one transfer at a time, mt counts cycles since the grant
  bit mb = 0, mrd = 0, moor = 0, mab = 0, mlast = 1;
  int mt = 0, mo = 0;
  logic [7:0] maddr = '0;
  logic [3:0] msel = '0;
  logic [31:0] mdat = '0;
  logic [31:0] ed [2];
  logic [31:0] mmem [256];
  initial begin
    int len;
    logic r0, r1;
    logic [9:0] a;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    ed[0] = '0;
    ed[1] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mb = 0; mt = 0; mab = 0; mlast = 1; ed[0] = '0; ed[1] = '0;
      end else if (mb) begin
        len = mrd ? 4 : 3;
        if (mt <= len - 2 && !cyc_of(mo)) mab = 1;
        if (mt == 1 && !mrd && !moor)
          for (int b = 0; b < 4; b++) if (msel[b]) mmem[maddr][8*b +: 8] = mdat[8*b +: 8];
        if (mt == len - 2 && mrd && !mab) ed[mo] = moor ? 32'h0 : mmem[maddr];
        mt++;
        if (mt == len) begin mb = 0; mt = 0; end
      end else begin
        r0 = m0.cyc_i & m0.stb_i;
        r1 = m1.cyc_i & m1.stb_i;
        if (r0 || r1) begin
          mo = (r0 && r1) ? (mlast ? 0 : 1) : (r1 ? 1 : 0);
          mlast = (mo == 1);
          a = mo != 0 ? m1.adr_i : m0.adr_i;
          moor = a >= 10'd256;
          maddr = a[7:0];
          mrd = !(mo != 0 ? m1.we_i : m0.we_i);
          msel = mo != 0 ? m1.sel_i : m0.sel_i;
          mdat = mo != 0 ? m1.dat_i : m0.dat_i;
          mab = 0; mb = 1; mt = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  initial begin
    int len;
    forever begin
      @(negedge clk);
      if (m0.ack_o === 1'b1) acks0++;
      if (m1.ack_o === 1'b1) acks1++;
      if (ram_csb0 === 1'b0) csb_lows++;
      if (rst_n) begin
        len = mrd ? 4 : 3;
        chk("grant", 32'(grant_o), mb ? (mo != 0 ? 32'd2 : 32'd1) : 32'd0);
        chk("ack0", 32'(m0.ack_o), 32'(mb && mt == len - 1 && !mab && mo == 0));
        chk("ack1", 32'(m1.ack_o), 32'(mb && mt == len - 1 && !mab && mo == 1));
        chk("csb0", 32'(ram_csb0), 32'(!(mb && mt == 1 && !moor)));
        chk("web0", 32'(ram_web0), 32'(!(mb && mt == 1 && !mrd)));
        chk("dat0", m0.dat_o, ed[0]);
        chk("dat1", m1.dat_o, ed[1]);
        if (mb && mt == 1 && !moor) begin
          chk("addr0", 32'(ram_addr0), 32'(maddr));
          chk("wmask0", 32'(ram_wmask0), 32'(msel));
          chk("din0", ram_din0, mdat);
        end
      end
    end
  end

  task automatic drive(input int p, input logic c, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [9:0] adr);
    if (p != 0) begin
      m1.cyc_i = c; m1.stb_i = c; m1.we_i = we; m1.sel_i = sel; m1.dat_i = dat; m1.adr_i = adr;
    end else begin
      m0.cyc_i = c; m0.stb_i = c; m0.we_i = we; m0.sel_i = sel; m0.dat_i = dat; m0.adr_i = adr;
    end
  endtask

  // Issue one transfer from a negedge; ab drops cyc as soon as the grant is seen
  task automatic txn(input int p, input logic we, input logic [9:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input bit ab, input int exp_lat);
    int lat = 0;
    bit done = 0;
    drive(p, 1'b1, we, sel, dat, adr);
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      done = ab ? grant_o[p] : ack_of(p);
    end
    drive(p, 1'b0, 1'b0, 4'h0, 32'h0, 10'h0);
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_timeout port %0d: no response after %0d cycles, expected one within 60", p, lat);
    end else if (exp_lat != 0) chk("ack_latency", lat, exp_lat);
    repeat (ab ? 4 : 1) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_csb0", 32'(ram_csb0), 32'd1);
    chk("rst_web0", 32'(ram_web0), 32'd1);
    chk("rst_wmask0", 32'(ram_wmask0), 32'd0);
    chk("rst_addr0", 32'(ram_addr0), 32'd0);
    chk("rst_din0", ram_din0, 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_ack0", 32'(m0.ack_o), 32'd0);
    chk("rst_ack1", 32'(m1.ack_o), 32'd0);
    chk("rst_dat0", m0.dat_o, 32'd0);
    chk("rst_dat1", m1.dat_o, 32'd0);
  endtask

  task automatic rand_master(input int p);
    logic [9:0] a;
    repeat (120) begin
      a = ($urandom % 8 == 0) ? 10'($urandom_range(256, 1023)) : 10'($urandom % 16);
      txn(p, 1'($urandom), a, 4'($urandom), $urandom, ($urandom % 10 == 0), 0);
      repeat ($urandom % 3) @(negedge clk);
    end
  endtask

  initial begin
    int c, a0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 10'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 10'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // simultaneous requests right after reset: m0, then m1, then m0 again
    fork
      txn(0, 1'b1, 10'h001, 4'hF, 32'h0000_0A0A, 0, 2);
      txn(1, 1'b1, 10'h002, 4'hF, 32'h0000_0B0B, 0, 5);
      begin
        @(posedge clk); @(negedge clk);
        chk("grant_first", 32'(grant_o), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("grant_second", 32'(grant_o), 32'd2);
      end
    join
    fork
      txn(0, 1'b1, 10'h003, 4'hF, 32'h0000_0C0C, 0, 2);
      txn(1, 1'b1, 10'h004, 4'hF, 32'h0000_0D0D, 0, 5);
      begin
        @(posedge clk); @(negedge clk);
        chk("grant_third", 32'(grant_o), 32'd1);
      end
    join
    txn(0, 1'b1, 10'h005, 4'hF, 32'hDEAD_BEEF, 0, 2);
    txn(0, 1'b0, 10'h005, 4'hF, 32'h0, 0, 3);
    chk("rd_deadbeef", m0.dat_o, 32'hDEAD_BEEF);
    txn(1, 1'b1, 10'h010, 4'hF, 32'h1122_3344, 0, 2);
    txn(1, 1'b1, 10'h010, 4'b0101, 32'hAABB_CCDD, 0, 2);
    txn(1, 1'b0, 10'h010, 4'hF, 32'h0, 0, 3);
    chk("rd_bytemask", m1.dat_o, 32'h11BB_33DD);
    txn(1, 1'b1, 10'h010, 4'h0, 32'hFFFF_FFFF, 0, 2);
    txn(1, 1'b0, 10'h010, 4'hF, 32'h0, 0, 3);
    chk("rd_sel_zero", m1.dat_o, 32'h11BB_33DD);
    c = csb_lows;
    txn(0, 1'b0, 10'h300, 4'hF, 32'h0, 0, 3);
    chk("oor_csb_never_low", csb_lows - c, 0);
    chk("oor_rd_zero", m0.dat_o, 32'h0);
    txn(0, 1'b1, 10'h105, 4'hF, 32'h5555_5555, 0, 2);
    txn(0, 1'b0, 10'h005, 4'hF, 32'h0, 0, 3);
    chk("oor_no_alias", m0.dat_o, 32'hDEAD_BEEF);
    a0 = acks0;
    txn(0, 1'b1, 10'h020, 4'hF, 32'hCAFE_F00D, 1, 0);
    chk("abort_no_ack", acks0 - a0, 0);
    txn(0, 1'b0, 10'h020, 4'hF, 32'h0, 0, 3);
    chk("abort_committed", m0.dat_o, 32'hCAFE_F00D);
    // reset pulse while a read sits in RDWAIT
    a0 = acks0;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h0, 10'h005);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 10'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_ack", acks0 - a0, 0);
    txn(0, 1'b0, 10'h005, 4'hF, 32'h0, 0, 3);
    chk("rd_after_rst", m0.dat_o, 32'hDEAD_BEEF);
    fork
      rand_master(0);
      rand_master(1);
    join
    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
